// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding and 16x oversampling constants.
// No logic; used by both the receiver and the transmitter.
package uart_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_POINT = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_16x_if.sv
// Received-word valid/ready channel plus its error qualifiers and overrun strobe.
// master = receiver side, slave = consumer side.
interface uart_rx_16x_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/sync_2ff.sv
// Generic 2-flop synchronizer for one async input; latency 2 clk.
// No backpressure; RESET_VAL sets the idle level the flops reset to.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/uart_rx_16x.sv
// UART receiver, 16x oversampled; rx_valid rises 1 clk after the final stop-bit centre sample.
// Word held until rx_ready; a frame finishing while the word is still held is dropped with an overrun pulse.
module uart_rx_16x
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_16x,
    input  logic          rx,
    output logic          busy,
    uart_rx_16x_if.master rx_if
);
    localparam int TW = $clog2(OVERSAMPLE);

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [TW-1:0]        r_tick_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par_err_q;
    logic                 r_frame_err_q;
    logic                 r_done;
    logic                 r_valid;
    logic                 r_par_err;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_rx_s;
    logic                 w_sample;
    logic                 w_last_data;
    logic                 w_last_stop;
    logic                 w_accept;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    assign w_sample    = tick_16x && (r_tick_cnt == TW'(SAMPLE_POINT));
    assign w_last_data = (r_bit_cnt == 4'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_cnt == 4'(STOP_BITS - 1));
    assign w_accept    = r_valid && rx_if.rx_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (tick_16x && !w_rx_s) w_state_nxt = START;
            START:   if (w_sample) w_state_nxt = w_rx_s ? IDLE : DATA;
            DATA:    if (w_sample && w_last_data) w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (w_sample) w_state_nxt = STOP;
            STOP:    if (w_sample && w_last_stop) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // tick_cnt is parked at 0 in IDLE, so the start-detect tick becomes tick 0 of the start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_par_err_q   <= 1'b0;
            r_frame_err_q <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (tick_16x) begin
                if (r_state == IDLE) r_tick_cnt <= '0;
                else                 r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            if (w_sample) begin
                case (r_state)
                    START: begin
                        r_bit_cnt     <= '0;
                        r_par_err_q   <= 1'b0;
                        r_frame_err_q <= 1'b0;
                    end
                    DATA: begin
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= w_last_data ? 4'd0 : r_bit_cnt + 1'b1;
                    end
                    PARITY: r_par_err_q <= ((^r_shift) ^ w_rx_s) != (PARITY_ODD != 0);
                    STOP: begin
                        if (!w_rx_s) r_frame_err_q <= 1'b1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_last_stop) r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Same-clk accept and delivery reloads the register without dropping rx_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_valid || w_accept) begin
                    r_data      <= r_shift;
                    r_par_err   <= r_par_err_q;
                    r_frame_err <= r_frame_err_q;
                    r_valid     <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign busy              = (r_state != IDLE);
    assign rx_if.rx_data     = r_data;
    assign rx_if.rx_valid    = r_valid;
    assign rx_if.parity_err  = r_par_err;
    assign rx_if.frame_err   = r_frame_err;
    assign rx_if.overrun_err = r_overrun;
endmodule
